// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequences one MEM-stage load/store at a time onto the
// data-memory port. It checks alignment, builds byte-lane enables and
// lane-replicated store data, runs req/gnt then rvalid with memory, and
// returns sign- or zero-extended load data. The pipeline is stalled while
// an access is outstanding.
//
// Handshakes:
//   pipeline side: an access is accepted on a rising edge where
//     req_valid && req_ready; req_ready is high only in IDLE.
//     Completion is a single-cycle rsp_valid pulse.
//   memory side: mem_req rises with all mem_* stable and stays high until
//     the edge that samples mem_gnt. For loads, data returns on a later
//     mem_rvalid, at least one cycle after the grant.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              stall,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  off_q;

   logic        accept;
   logic        req_err;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;

   assign accept    = (state == IDLE) && req_valid;
   assign req_ready = (state == IDLE);
   assign stall     = (state == REQ) || (state == WAIT);
   assign mem_req   = (state == REQ);
   assign rsp_valid = (state == RESP);
   assign dbg_state = state;

   // Decode the incoming request: lane enables, replicated store data, alignment error
   always_comb begin
      lane_be    = 4'b0000;
      lane_wdata = 32'h0;
      req_err    = 1'b0;
      case (req_size)
         2'b00: begin
            lane_be    = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            lane_be    = 4'b0011 << {req_addr[1], 1'b0};
            lane_wdata = {2{req_wdata[15:0]}};
            req_err    = req_addr[0];
         end
         2'b10: begin
            lane_be    = 4'b1111;
            lane_wdata = req_wdata;
            req_err    = |req_addr[1:0];
         end
         default: begin
            req_err = 1'b1;
         end
      endcase
      // Loads still drive the lane enables but never put data on the bus
      if (!req_we) begin
         lane_wdata = 32'h0;
      end
   end

   // Pick the addressed byte/half out of the returned word and extend it
   always_comb begin
      load_byte = mem_rdata[7:0];
      load_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (off_q)
         2'd0:    load_byte = mem_rdata[7:0];
         2'd1:    load_byte = mem_rdata[15:8];
         2'd2:    load_byte = mem_rdata[23:16];
         default: load_byte = mem_rdata[31:24];
      endcase
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & load_byte[7]}}, load_byte};
         2'b01:   load_ext = {{16{~uns_q & load_half[15]}}, load_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Next-state logic for the access sequencer
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = req_err ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_next = mem_we ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_next = RESP;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Memory-port and request-attribute registers, loaded only on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
         size_q    <= 2'b00;
         uns_q     <= 1'b0;
         off_q     <= 2'b00;
      end else if (accept) begin
         mem_we    <= req_we;
         mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
         mem_be    <= lane_be;
         mem_wdata <= lane_wdata;
         size_q    <= req_size;
         uns_q     <= req_unsigned;
         off_q     <= req_addr[1:0];
      end
   end

   // Response registers, updated only on the transition into RESP and held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept && req_err) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
         end else if ((state == REQ) && mem_gnt && mem_we) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
         end else if ((state == WAIT) && mem_rvalid) begin
            rsp_rdata <= load_ext;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized accesses checked against a behavioural model.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_rsp    = 0;
   logic [32:0] exp_q[$];
   logic [32:0] exp_e;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_wait;
      int          rv_wait;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[16];

   lsu_mem_ctrl #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_gnt      (mem_gnt),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .dbg_state    (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard: every response pulse pops one expected {err, rdata}
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (t=%0t)", $time);
         end else begin
            exp_e = exp_q.pop_front();
            check("sb_rsp_err", {31'd0, rsp_err}, {31'd0, exp_e[32]});
            check("sb_rsp_rdata", rsp_rdata, exp_e[31:0]);
         end
      end
   end

   // behavioural reference: lanes, replicated data and extension from byte arithmetic
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        output logic [3:0] be, output logic [31:0] mwd,
                        output logic err, output logic [31:0] rd);
      int          nb;
      int          off;
      logic [63:0] mask;
      logic [63:0] v;
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off  = int'(addr % 32'd4);
      err  = (size == 2'd3) || ((off % nb) != 0);
      be   = 4'b0000;
      mwd  = 32'h0;
      rd   = 32'h0;
      if (!err) begin
         for (int i = 0; i < nb; i++) be[off + i] = 1'b1;
         if (we) begin
            for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wdata[8*(i % nb) +: 8];
         end else begin
            mask = (64'd1 << (8*nb)) - 64'd1;
            v    = ({32'd0, rdata} >> (8*off)) & mask;
            if (!uns && v[8*nb-1]) v = v | ~mask;
            rd = v[31:0];
         end
      end
   endtask

   // driver: one complete access with memory responding after the given delays
   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_wait, input int rv_wait,
                         input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic e_err, input logic [31:0] e_rdata);
      logic [31:0] e_addr;
      e_addr = {addr[31:2], 2'b00};
      exp_q.push_back({e_err, e_rdata});
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (e_err) begin
         check("err_no_mem_req", {31'd0, mem_req}, 32'd0);
         check("err_rsp_at_t1", {31'd0, rsp_valid}, 32'd1);
         check("err_no_stall", {31'd0, stall}, 32'd0);
      end else begin
         for (int k = 0; k <= gnt_wait; k++) begin
            check("req_mem_req", {31'd0, mem_req}, 32'd1);
            check("req_stall", {31'd0, stall}, 32'd1);
            check("req_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("req_mem_we", {31'd0, mem_we}, {31'd0, we});
            check("req_mem_addr", mem_addr, e_addr);
            check("req_mem_be", {28'd0, mem_be}, {28'd0, e_be});
            check("req_mem_wdata", mem_wdata, e_wdata);
            if (k == gnt_wait) mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
         end
         if (!we) begin
            for (int j = 1; j <= rv_wait; j++) begin
               check("wait_stall", {31'd0, stall}, 32'd1);
               check("wait_mem_req_low", {31'd0, mem_req}, 32'd0);
               check("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
               if (j == rv_wait) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = rdata;
               end
               @(negedge clk);
               mem_rvalid = 1'b0;
               mem_rdata  = $urandom;
            end
         end
         check("rsp_pulse", {31'd0, rsp_valid}, 32'd1);
         check("rsp_no_stall", {31'd0, stall}, 32'd0);
         check("rsp_not_ready", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clk);
      check("rsp_single_cycle", {31'd0, rsp_valid}, 32'd0);
      check("hold_rsp_rdata", rsp_rdata, e_rdata);
      check("hold_rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic        r_we;
      logic [1:0]  r_size;
      logic        r_uns;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      logic [31:0] r_rdata;
      logic [3:0]  m_be;
      logic [31:0] m_wd;
      logic        m_err;
      logic [31:0] m_rd;
      int          rsp_before;

      //           we    size   uns   addr          wdata         rdata         gw rv  be       wdata         err   rdata
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         0, 0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 3, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001};
      vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 3, 4'b1100, 32'h0,         1'b0, 32'h0000_8001};
      vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         1'b1, 32'h0};
      vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h0000_1234, 32'h0,         5, 0, 4'b1100, 32'h1234_1234, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_00F0, 0, 1, 4'b0001, 32'h0,         1'b0, 32'hFFFF_FFF0};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_F000, 1, 2, 4'b0010, 32'h0,         1'b0, 32'h0000_00F0};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 2, 1, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0024, 32'h1234_5678, 32'h0,         1, 0, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         1'b1, 32'h0};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0031, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         1'b1, 32'h0};
      vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0042, 32'hFFFF_FF7E, 32'h0,         0, 0, 4'b0100, 32'h7E7E_7E7E, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_0053, 32'h0,         32'h7F00_0000, 0, 1, 4'b1000, 32'h0,         1'b0, 32'h0000_007F};
      vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_0060, 32'h0,         32'h1234_ABCD, 0, 2, 4'b0011, 32'h0,         1'b0, 32'h0000_ABCD};
      vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h0000_0060, 32'h0,         32'h1234_ABCD, 3, 1, 4'b0011, 32'h0,         1'b0, 32'hFFFF_ABCD};
      vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h0000_0070, 32'h5555_5555, 32'h0,         0, 0, 4'b0000, 32'h0,         1'b1, 32'h0};

      // reset
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      mem_gnt      = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = 32'h0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors
      for (int i = 0; i < 16; i++) begin
         access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                vecs[i].gnt_wait, vecs[i].rv_wait, vecs[i].e_be, vecs[i].e_wdata,
                vecs[i].e_err, vecs[i].e_rdata);
      end

      // randomized accesses against the model
      for (int i = 0; i < 40; i++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_size  = 2'($urandom_range(0, 3));
         r_uns   = 1'($urandom_range(0, 1));
         r_addr  = $urandom;
         r_wdata = $urandom;
         r_rdata = $urandom;
         model(r_we, r_size, r_uns, r_addr, r_wdata, r_rdata, m_be, m_wd, m_err, m_rd);
         access(r_we, r_size, r_uns, r_addr, r_wdata, r_rdata,
                $urandom_range(0, 3), $urandom_range(1, 3), m_be, m_wd, m_err, m_rd);
      end

      // back-to-back SW then LB with req_valid held high throughout
      rsp_before = n_rsp;
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'hFFFF_FF80});
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h0000_0080;
      req_wdata    = 32'hCAFE_F00D;
      @(negedge clk);
      check("b2b_sw_addr", mem_addr, 32'h0000_0080);
      check("b2b_sw_be", {28'd0, mem_be}, 32'hF);
      check("b2b_sw_wdata", mem_wdata, 32'hCAFE_F00D);
      check("b2b_req_not_ready", {31'd0, req_ready}, 32'd0);
      req_we   = 1'b0;
      req_size = 2'b00;
      req_addr = 32'h0000_0091;
      mem_gnt  = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("b2b_sw_rsp", {31'd0, rsp_valid}, 32'd1);
      check("b2b_resp_not_ready", {31'd0, req_ready}, 32'd0);
      check("b2b_resp_mem_addr_held", mem_addr, 32'h0000_0080);
      @(negedge clk);
      check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
      check("b2b_idle_mem_be_held", {28'd0, mem_be}, 32'hF);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_lb_mem_req", {31'd0, mem_req}, 32'd1);
      check("b2b_lb_addr", mem_addr, 32'h0000_0090);
      check("b2b_lb_be", {28'd0, mem_be}, 32'h2);
      check("b2b_lb_we", {31'd0, mem_we}, 32'd0);
      check("b2b_lb_wdata", mem_wdata, 32'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt    = 1'b0;
      check("b2b_lb_wait_stall", {31'd0, stall}, 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_8000;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("b2b_lb_rsp", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      check("b2b_rsp_count", n_rsp - rsp_before, 32'd2);
      check("exp_q_drained", exp_q.size(), 32'd0);

      // reset asserted while waiting for read data abandons the access
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_addr     = 32'h0000_00A0;
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("rst_pre_wait_stall", {31'd0, stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stray_rvalid_no_rsp", {31'd0, rsp_valid}, 32'd0);
         check("stray_rvalid_rdata", rsp_rdata, 32'd0);
         @(negedge clk);
      end
      check("final_exp_q_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
